// File: rtl/instr_encoder.sv
// Packs symbolic RV32 instruction requests into machine words and streams them,
// through a small FIFO, into sequential instruction-memory addresses.
module instr_encoder #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [19:0]       req_imm,
    input  logic              flush,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [31:0]       r_last;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_legal;
    logic [31:0] w_word;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;

    assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    // Encoder: decode format/op into funct fields, then assemble the word.
    always_comb begin
        w_legal = 1'b0;
        w_word  = '0;
        w_f7    = '0;
        w_f3    = '0;
        case (req_fmt)
            3'b000: begin
                w_legal = 1'b1;
                case (req_op)
                    4'h0: w_f3 = 3'b000;
                    4'h1: w_f7 = 7'b0100000;
                    4'h2: w_f3 = 3'b111;
                    4'h3: w_f3 = 3'b110;
                    4'h4: w_f3 = 3'b100;
                    4'h5: w_f3 = 3'b001;
                    4'h6: begin w_f7 = 7'b0100000; w_f3 = 3'b101; end
                    4'h7: w_f3 = 3'b101;
                    4'h8: w_f3 = 3'b010;
                    4'h9: w_f3 = 3'b011;
                    4'hA: w_f7 = 7'b0000001;
                    4'hB: begin w_f7 = 7'b0000001; w_f3 = 3'b001; end
                    4'hC: begin w_f7 = 7'b0000001; w_f3 = 3'b011; end
                    4'hD: w_f3 = 3'b001;
                    default: w_legal = 1'b0;
                endcase
                if (req_op == 4'hD) begin
                    w_word = {req_imm[11:0], req_rs1, w_f3, req_rd, 7'b1110011};
                end else begin
                    w_word = {w_f7, req_rs2, req_rs1, w_f3, req_rd, 7'b0110011};
                end
            end
            3'b001: begin
                w_legal = 1'b1;
                case (req_op)
                    4'h0: w_f3 = 3'b000;
                    4'h1: w_f3 = 3'b111;
                    4'h2: w_f3 = 3'b110;
                    4'h3: w_f3 = 3'b100;
                    4'h4: w_f3 = 3'b001;
                    4'h5: begin w_f7 = 7'b0100000; w_f3 = 3'b101; end
                    4'h6: w_f3 = 3'b101;
                    default: w_legal = 1'b0;
                endcase
                // Shifts carry only a 5-bit shamt under a funct7-style upper field.
                if (req_op == 4'h4 || req_op == 4'h5 || req_op == 4'h6) begin
                    w_word = {w_f7, req_imm[4:0], req_rs1, w_f3, req_rd, 7'b0010011};
                end else begin
                    w_word = {req_imm[11:0], req_rs1, w_f3, req_rd, 7'b0010011};
                end
            end
            3'b010: begin
                w_legal = (req_op == 4'h0);
                w_word  = {req_imm, req_rd, 7'b0110111};
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept = req_valid && !w_full && !flush;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = !w_empty && imem_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
            r_addr   <= '0;
            r_err    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_addr   <= r_addr + ADDR_W'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    assign req_ready  = !w_full;
    assign imem_we    = !w_empty;
    assign busy       = !w_empty;
    assign imem_addr  = r_addr;
    // Once drained, keep presenting the last word that was written.
    assign imem_wdata = w_empty ? r_last : r_mem[r_rd_ptr];
    assign err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_fmt;
    logic [3:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [19:0] req_imm;
    logic        flush;
    logic        imem_ready;

    logic        req_ready, imem_we, busy, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;

    logic        w2_req_ready, w2_imem_we, w2_busy, w2_err;
    logic [1:0]  w2_imem_addr;
    logic [31:0] w2_imem_wdata;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .flush(flush), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
        .busy(busy), .err(err)
    );

    instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w2_req_ready),
        .req_fmt(req_fmt), .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .flush(flush), .imem_we(w2_imem_we),
        .imem_addr(w2_imem_addr), .imem_wdata(w2_imem_wdata), .imem_ready(imem_ready),
        .busy(w2_busy), .err(w2_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] mq[$];
    int          m_pops;
    logic        m_err;
    logic [31:0] m_last;

    // Funct tables indexed by op code (-1 marks illegal)
    int r_f7 [16] = '{0, 32, 0, 0, 0, 0, 32, 0, 0, 0, 1, 1, 1, -1, -1, -1};
    int r_f3 [16] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3, 0, 1, 3, -1, -1, -1};
    int i_f3 [7]  = '{0, 7, 6, 4, 1, 5, 5};

    typedef struct {
        logic [2:0]  fmt;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [19:0] imm;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_enc(input int fmt, input int op, input int rd, input int rs1,
                                    input int rs2, input int imm,
                                    output logic [31:0] w, output bit lg);
        int unsigned v;
        v  = 0;
        lg = 1'b0;
        if (fmt == 0 && op == 13) begin
            lg = 1'b1;
            v  = (imm % 4096) * 2**20 + rs1 * 2**15 + 1 * 2**12 + rd * 2**7 + 115;
        end else if (fmt == 0 && r_f7[op] >= 0) begin
            lg = 1'b1;
            v  = r_f7[op] * 2**25 + rs2 * 2**20 + rs1 * 2**15 + r_f3[op] * 2**12
               + rd * 2**7 + 51;
        end else if (fmt == 1 && op < 7) begin
            lg = 1'b1;
            if (op >= 4) begin
                v = ((op == 5) ? 32 : 0) * 2**25 + (imm % 32) * 2**20;
            end else begin
                v = (imm % 4096) * 2**20;
            end
            v = v + rs1 * 2**15 + i_f3[op] * 2**12 + rd * 2**7 + 19;
        end else if (fmt == 2 && op == 0) begin
            lg = 1'b1;
            v  = imm * 2**12 + rd * 2**7 + 55;
        end
        w = v;
    endfunction

    task automatic check_outputs();
        logic [31:0] exp_wdata;
        exp_wdata = (mq.size() > 0) ? mq[0] : m_last;
        chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
        chk("imem_we", 32'(imem_we), 32'(mq.size() > 0));
        chk("busy", 32'(busy), 32'(mq.size() > 0));
        chk("err", 32'(err), 32'(m_err));
        chk("imem_addr", 32'(imem_addr), 32'(m_pops % 256));
        chk("imem_wdata", imem_wdata, exp_wdata);
        chk("wrap_addr", 32'(w2_imem_addr), 32'(m_pops % 4));
    endtask

    // Advance one cycle: update the model from the inputs driven now, then check.
    task automatic step();
        logic [31:0] w;
        bit          lg;
        bit          rdy;
        bit          pop;
        ref_enc(int'(req_fmt), int'(req_op), int'(req_rd), int'(req_rs1), int'(req_rs2),
                int'(req_imm), w, lg);
        rdy = mq.size() < DEPTH;
        pop = (mq.size() > 0) && imem_ready;
        if (!rst_n) begin
            mq.delete();
            m_pops = 0;
            m_err  = 1'b0;
            m_last = '0;
        end else if (flush) begin
            mq.delete();
            m_pops = 0;
            m_err  = 1'b0;
        end else begin
            if (pop) begin
                m_last = mq.pop_front();
                m_pops = (m_pops + 1) % 256;
            end
            if (req_valid && rdy) begin
                if (lg) mq.push_back(w);
                else    m_err = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_req(input logic [2:0] fmt, input logic [3:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [19:0] imm);
        req_valid = 1'b1;
        req_fmt   = fmt;
        req_op    = op;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
    endtask

    task automatic do_flush();
        req_valid = 1'b0;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
    endtask

    initial begin
        int exp_addr;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_fmt    = '0;
        req_op     = '0;
        req_rd     = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_imm    = '0;
        flush      = 1'b0;
        imem_ready = 1'b1;
        mq.delete();
        m_pops = 0;
        m_err  = 1'b0;
        m_last = '0;

        tbl[0]  = '{3'b000, 4'h0, 5'd3,  5'd1,  5'd2,  20'h0,     1'b1, 32'h002081B3};
        tbl[1]  = '{3'b000, 4'h1, 5'd5,  5'd6,  5'd7,  20'h0,     1'b1, 32'h407302B3};
        tbl[2]  = '{3'b001, 4'h0, 5'd1,  5'd0,  5'd9,  20'h5,     1'b1, 32'h00500093};
        tbl[3]  = '{3'b001, 4'h5, 5'd4,  5'd4,  5'd0,  20'h3,     1'b1, 32'h40325213};
        tbl[4]  = '{3'b010, 4'h0, 5'd2,  5'd0,  5'd0,  20'h12345, 1'b1, 32'h12345137};
        tbl[5]  = '{3'b000, 4'hD, 5'd1,  5'd2,  5'd0,  20'h300,   1'b1, 32'h300110F3};
        tbl[6]  = '{3'b000, 4'hA, 5'd10, 5'd11, 5'd12, 20'h0,     1'b1, 32'h02C58533};
        tbl[7]  = '{3'b001, 4'h4, 5'd5,  5'd6,  5'd0,  20'hFE7,   1'b1, 32'h00731293};
        tbl[8]  = '{3'b000, 4'h2, 5'd1,  5'd2,  5'd3,  20'h0,     1'b1, 32'h003170B3};
        tbl[9]  = '{3'b010, 4'h0, 5'd31, 5'd5,  5'd9,  20'hFFFFF, 1'b1, 32'hFFFFFFB7};
        tbl[10] = '{3'b011, 4'h0, 5'd1,  5'd1,  5'd1,  20'h1,     1'b0, 32'h0};
        tbl[11] = '{3'b001, 4'h7, 5'd1,  5'd1,  5'd1,  20'h1,     1'b0, 32'h0};
        tbl[12] = '{3'b000, 4'hE, 5'd1,  5'd1,  5'd1,  20'h1,     1'b0, 32'h0};
        tbl[13] = '{3'b010, 4'h1, 5'd1,  5'd1,  5'd1,  20'h1,     1'b0, 32'h0};

        // Reset state
        @(negedge clk);
        check_outputs();
        chk("rst_wdata", imem_wdata, 32'h0);
        rst_n = 1'b1;

        // Directed vector table, imem_ready held high
        exp_addr = 0;
        foreach (tbl[i]) begin
            drive_req(tbl[i].fmt, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            step();
            chk("vec_we", 32'(imem_we), 32'(tbl[i].legal));
            chk("vec_err", 32'(err), 32'(!tbl[i].legal));
            if (tbl[i].legal) begin
                chk("vec_wdata", imem_wdata, tbl[i].word);
                chk("vec_addr", 32'(imem_addr), 32'(exp_addr));
                exp_addr++;
            end
            req_valid = 1'b0;
            step();
        end

        // Illegal requests leave err set; a following legal addi still lands at addr 0
        do_flush();
        drive_req(3'b011, 4'h0, 5'd1, 5'd1, 5'd1, 20'h1);
        step();
        drive_req(3'b000, 4'hE, 5'd1, 5'd1, 5'd1, 20'h1);
        step();
        chk("ill_we", 32'(imem_we), 32'h0);
        chk("ill_err", 32'(err), 32'h1);
        drive_req(3'b001, 4'h0, 5'd1, 5'd0, 5'd0, 20'h5);
        step();
        chk("ill_addi_addr", 32'(imem_addr), 32'h0);
        chk("ill_addi_wdata", imem_wdata, 32'h00500093);
        req_valid = 1'b0;
        step();
        do_flush();
        chk("flush_err", 32'(err), 32'h0);

        // Backpressure: 6 back-to-back requests with memory stalled
        imem_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_req(3'b001, 4'h0, 5'd1, 5'd0, 5'd0, 20'(k + 16));
            step();
        end
        chk("bp_full_ready", 32'(req_ready), 32'h0);
        req_valid  = 1'b0;
        imem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_addr", 32'(imem_addr), 32'(k));
            chk("bp_wdata", imem_wdata, 32'h00000093 + 32'((k + 16) << 20));
            step();
            if (k == 0) chk("bp_ready_back", 32'(req_ready), 32'h1);
        end
        chk("bp_drained", 32'(busy), 32'h0);

        // Address wrap on the ADDR_W=2 instance
        do_flush();
        for (int k = 0; k < 5; k++) begin
            drive_req(3'b010, 4'h0, 5'd3, 5'd0, 5'd0, 20'(k + 1));
            step();
            chk("wrap_seq_addr", 32'(w2_imem_addr), 32'(k % 4));
            chk("wrap_seq_we", 32'(w2_imem_we), 32'h1);
        end
        req_valid = 1'b0;
        step();

        // Flush with 3 words queued
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_req(3'b000, 4'h4, 5'(k + 1), 5'd2, 5'd3, 20'h0);
            step();
        end
        do_flush();
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_we", 32'(imem_we), 32'h0);
        imem_ready = 1'b1;
        drive_req(3'b001, 4'h1, 5'd7, 5'd8, 5'd0, 20'hABC);
        step();
        chk("flush_next_addr", 32'(imem_addr), 32'h0);
        req_valid = 1'b0;
        step();

        // Asynchronous reset with 3 words queued
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_req(3'b000, 4'h8, 5'(k + 4), 5'd2, 5'd3, 20'h0);
            step();
        end
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_we", 32'(imem_we), 32'h0);
        chk("rst_wdata_mid", imem_wdata, 32'h0);
        step();
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        drive_req(3'b000, 4'h9, 5'd9, 5'd10, 5'd11, 20'h0);
        step();
        chk("rst_next_addr", 32'(imem_addr), 32'h0);
        req_valid = 1'b0;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(0, 9) < 7);
            req_fmt    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                                     : 3'($urandom_range(0, 2));
            req_op     = (req_fmt == 3'b010 && $urandom_range(0, 3) != 0) ? 4'h0
                                                                          : 4'($urandom);
            req_rd     = 5'($urandom);
            req_rs1    = 5'($urandom);
            req_rs2    = 5'($urandom);
            req_imm    = 20'($urandom);
            imem_ready = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 49) == 0);
            rst_n      = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-image writer for the RIU core. It is the encoding counterpart of the control-unit decoder. It accepts symbolic instruction requests (format, 4-bit op code, register fields, immediate) over a valid/ready handshake and packs each into a 32-bit RV32 machine word. Words are buffered in a small FIFO and written sequentially into instruction memory through a ready-gated write port. It sits between the testbench/boot loader and the instruction memory.

## Interface
- `ADDR_W`, 8, instruction-memory word-address width; address counter wraps at 2^ADDR_W.
- `FIFO_DEPTH`, 4, encoded-word buffer entries (power of 2, ≥2).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  = !fifo_full.
- `req_fmt`  in  3  000 R-type, 001 I-type, 010 U-type; all others illegal.
- `req_op`  in  4  op code, same numbering the decoder emits (see Operation).
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register fields.
- `req_imm`  in  20  immediate; I-type and csrrw use [11:0], shifts use [4:0], U-type uses [19:0].
- `flush`  in  1  synchronous clear of FIFO, address counter, and err.
- `imem_we`  out  1  = FIFO non-empty.
- `imem_addr`  out  ADDR_W  word address of the current head.
- `imem_wdata`  out  32  encoded word at the FIFO head.
- `imem_ready`  in  1  memory accepts the write this cycle.
- `busy`  out  1  FIFO non-empty.
- `err`  out  1  sticky; an illegal request was seen.

## Operation
- Accept: `req_valid && req_ready` at a rising edge. A legal request pushes its encoded word. An illegal request is consumed, sets `err`, and pushes nothing.
- R ops, opcode 0110011, funct7/funct3:
  - add 0000: 0/000
  - sub 0001: 0100000/000
  - and 0010: 0/111
  - or 0011: 0/110
  - xor 0100: 0/100
  - sll 0101: 0/001
  - sra 0110: 0100000/101
  - srl 0111: 0/101
  - slt 1000: 0/010
  - sltu 1001: 0/011
  - mul 1010: 0000001/000
  - mulh 1011: 0000001/001
  - mulhu 1100: 0000001/011
  - 1110 and 1111 are illegal.
- csrrw, R op 1101: {imm[11:0], rs1, 001, rd, 1110011}.
- I ops, opcode 0010011, {imm[11:0], rs1, f3, rd, op}:
  - addi 0000: f3 000
  - andi 0001: f3 111
  - ori 0010: f3 110
  - xori 0011: f3 100
  - slli 0100: f3 001, upper bits {0000000, imm[4:0]}
  - srai 0101: f3 101, upper bits {0100000, imm[4:0]}
  - srli 0110: f3 101, upper bits {0000000, imm[4:0]}
  - 0111 and above are illegal.
- U ops: lui 0000 → {imm[19:0], rd, 0110111}. Any other op is illegal.
- `req_rs2` is ignored for I/U formats, and `req_rs1` is ignored for U format.
- Write: head transfers when `imem_we && imem_ready`. On transfer, the FIFO pops and the address counter increments, wrapping 2^ADDR_W−1 → 0.
- Order: words are written in acceptance order with no gaps in address.

## Timing
- Reset values: `req_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `err`=0. FIFO pointers and address counter are 0.
- Latency: a word accepted at edge N drives `imem_we`=1 from just after edge N, so the earliest transfer is edge N+1.
- Throughput is one word per cycle with `imem_ready` held at 1.
- `imem_addr`/`imem_wdata` are stable while `imem_we`=1 and `imem_ready`=0.
- Full: `req_ready`=0. A pop in the same cycle does not raise `req_ready` until the following cycle.
- Simultaneous push and pop when not full: both happen and occupancy is unchanged.
- Empty: `imem_wdata` holds the last popped value. `imem_ready` is ignored.
- `flush` has priority over push, pop, and err-set in the same cycle. A request presented during `flush` is dropped.
- `rst_n` low mid-operation: immediate return to reset values. Pending words are lost and nothing is written.

## Test plan
- R-type `add` x3,x1,x2 (fmt 000, op 0000, `imem_ready`=1) → single write, addr 0, wdata 0x002081B3. `sub` x5,x6,x7 → addr 1, wdata 0x407302B3.
- I/U-type sequence:
  - `addi` x1,x0,5 → 0x00500093
  - `srai` x4,x4,3 → 0x40325213
  - `lui` x2,0x12345 → 0x12345137
  - Addresses are 0, 1, 2 on consecutive cycles.
- Backpressure: `imem_ready`=0, present 6 back-to-back requests.
  - 4 are accepted, then `req_ready`=0.
  - Raise `imem_ready`: 4 writes in order, addr 0–3, and `req_ready` returns the cycle after the first pop.
- Illegal inputs: fmt 011, I op 0111, and R op 1110 → `err`=1 and no `imem_we`. A following legal `addi` is still written at addr 0. `flush` clears `err`.
- Wrap: ADDR_W=2, write 5 words → addresses 0, 1, 2, 3, 0.
- Reset/flush mid-stream: with 3 words queued, pulse `flush` (or drop `rst_n`) → `busy`=0 and `imem_we`=0 next cycle, and the next request is written at addr 0.
